// File: rtl/ifid_ctrl_pkg.sv
// Shared encodings and widths for the IF/ID stage sequencer.
// Optional PERF_CNT_EN build macro is consumed by ifid_stage_ctrl.
package ifid_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MISS  = 2'd1,
      ST_FLUSH = 2'd2
   } ifid_state_e;

   localparam int REG_ZERO    = 0;
   localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/ifid_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources in IF/ID.
// Register zero never creates a dependency.
module ifid_hazard_detect
   import ifid_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             idex_mem_read_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   output logic             load_use_o
);

   assign load_use_o = idex_mem_read_i
                     & (idex_rt_i != REG_W'(REG_ZERO))
                     & ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/ifid_stage_ctrl.sv
// PC / IF-ID sequencer: RUN, MISS and FLUSH states with miss timeout and stall counter.
// Define PERF_CNT_EN to build the stall_cycles_o performance counter.
module ifid_stage_ctrl
   import ifid_ctrl_pkg::*;
#(
   parameter int REG_W          = 5,
   parameter int BRANCH_PENALTY = 1,
   parameter int MISS_TIMEOUT   = 64
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             hit_i,
   input  logic             branch_taken_i,
   input  logic             idex_mem_read_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             miss_err_o,
   output logic [31:0]      stall_cycles_o
);

   localparam int MCW = $clog2(MISS_TIMEOUT + 1);
   localparam logic [MCW-1:0]         MT_C = MCW'(MISS_TIMEOUT);
   localparam logic [FLUSH_CNT_W-1:0] BP_C = FLUSH_CNT_W'(BRANCH_PENALTY);

   ifid_state_e            state_q, state_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [MCW-1:0]         miss_cnt_q, miss_cnt_d;
   logic                   miss_err_q, miss_err_d;
   logic                   load_use;
   logic                   run_like;
   logic                   pc_write, ifid_write, ifid_flush, idex_bubble;

   ifid_hazard_detect #(.REG_W(REG_W)) u_hazard (
      .idex_mem_read_i (idex_mem_read_i),
      .idex_rt_i       (idex_rt_i),
      .ifid_rs_i       (ifid_rs_i),
      .ifid_rt_i       (ifid_rt_i),
      .load_use_o      (load_use)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         miss_cnt_q  <= '0;
         miss_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         miss_err_q  <= miss_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      miss_err_d  = miss_err_q;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      run_like    = 1'b0;

      unique case (state_q)
         ST_FLUSH: begin
            if (branch_taken_i) begin
               pc_write    = 1'b1;
               ifid_flush  = 1'b1;
               flush_cnt_d = BP_C;
            end else if (!hit_i) begin
               ifid_flush  = 1'b1;
               state_d     = ST_MISS;
               miss_cnt_d  = MCW'(1);
               flush_cnt_d = '0;
            end else begin
               pc_write    = 1'b1;
               ifid_flush  = 1'b1;
               flush_cnt_d = flush_cnt_q - 1'b1;
               if (flush_cnt_q <= FLUSH_CNT_W'(1)) state_d = ST_RUN;
            end
         end
         ST_MISS: begin
            if (!branch_taken_i && !hit_i) begin
               ifid_flush = 1'b1;
               if (miss_cnt_q < MT_C) miss_cnt_d = miss_cnt_q + MCW'(1);
            end else begin
               run_like = 1'b1;
            end
         end
         default: run_like = 1'b1;
      endcase

      // A returning hit or a redirect out of MISS is handled exactly like RUN.
      if (run_like) begin
         state_d    = ST_RUN;
         miss_cnt_d = '0;
         if (branch_taken_i) begin
            pc_write   = 1'b1;
            ifid_flush = 1'b1;
            if (BRANCH_PENALTY > 0) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = BP_C;
            end
         end else if (!hit_i) begin
            ifid_flush = 1'b1;
            state_d    = ST_MISS;
            miss_cnt_d = MCW'(1);
         end else if (load_use) begin
            idex_bubble = 1'b1;
         end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
         end
      end

      if (miss_cnt_d == MT_C) miss_err_d = 1'b1;

      if (!rst_n_i) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   assign pc_write_o    = pc_write;
   assign ifid_write_o  = ifid_write;
   assign ifid_flush_o  = ifid_flush;
   assign idex_bubble_o = idex_bubble;
   assign miss_err_o    = miss_err_q;

`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)      stall_cnt_q <= '0;
      else if (!pc_write) stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cycles_o = stall_cnt_q;
`else
   assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_ifid_stage_ctrl.sv
// Directed bench for ifid_stage_ctrl; stall counter expectations follow PERF_CNT_EN.
module tb_ifid_stage_ctrl;
   import ifid_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hit, branch_taken, idex_mem_read;
   logic [4:0]  idex_rt, ifid_rs, ifid_rt;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, miss_err;
   logic [31:0] stall_cycles;
   logic [3:0]  outs;
   int          checks = 0;
   int          passes = 0;

   assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble};

   always #5 clk = ~clk;

   ifid_stage_ctrl #(.REG_W(5), .BRANCH_PENALTY(1), .MISS_TIMEOUT(64)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .hit_i           (hit),
      .branch_taken_i  (branch_taken),
      .idex_mem_read_i (idex_mem_read),
      .idex_rt_i       (idex_rt),
      .ifid_rs_i       (ifid_rs),
      .ifid_rt_i       (ifid_rt),
      .pc_write_o      (pc_write),
      .ifid_write_o    (ifid_write),
      .ifid_flush_o    (ifid_flush),
      .idex_bubble_o   (idex_bubble),
      .miss_err_o      (miss_err),
      .stall_cycles_o  (stall_cycles)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hit = 1'b1; branch_taken = 1'b0; idex_mem_read = 1'b0;
      idex_rt = 5'd0; ifid_rs = 5'd1; ifid_rt = 5'd2;
   endtask

   task automatic apply_reset();
      idle_inputs();
      tick();
      rst_n = 1'b0;
      #2;
      tick();
      rst_n = 1'b1;
      #2;
   endtask

   function automatic logic [31:0] exp_stall(input int n);
`ifdef PERF_CNT_EN
      return 32'(n);
`else
      return 32'd0 + 32'(n) * 32'd0;
`endif
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #3;
      checks++;
      if (outs !== 4'b0011) $display("FAIL reset_outs got=%b exp=0011", outs);
      else passes++;
      checks++;
      if (miss_err !== 1'b0 || stall_cycles !== 32'd0)
         $display("FAIL reset_regs got err=%b stall=%0d exp err=0 stall=0", miss_err, stall_cycles);
      else passes++;
      tick();
      tick();
      rst_n = 1'b1;
      #2;
      $display("test_reset done");
   endtask

   task automatic test_run();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (outs !== 4'b1100) $display("FAIL run_cycle%0d got=%b exp=1100", i, outs);
         else passes++;
         tick();
      end
      checks++;
      if (stall_cycles !== 32'd0) $display("FAIL run_stall got=%0d exp=0", stall_cycles);
      else passes++;
      $display("test_run done");
   endtask

   task automatic test_miss();
      apply_reset();
      hit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         checks++;
         if (outs !== 4'b0010) $display("FAIL miss_cycle%0d got=%b exp=0010", i, outs);
         else passes++;
         tick();
      end
      hit = 1'b1;
      #2;
      checks++;
      if (outs !== 4'b1100) $display("FAIL miss_hit_return got=%b exp=1100", outs);
      else passes++;
      tick();
      checks++;
      if (dut.state_q !== ST_RUN || dut.miss_cnt_q !== 7'd0)
         $display("FAIL miss_back_to_run got state=%0d cnt=%0d exp state=0 cnt=0", dut.state_q, dut.miss_cnt_q);
      else passes++;
      checks++;
      if (stall_cycles !== exp_stall(3)) $display("FAIL miss_stall got=%0d exp=%0d", stall_cycles, exp_stall(3));
      else passes++;
      $display("test_miss done");
   endtask

   task automatic test_load_use();
      apply_reset();
      idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
      #2;
      checks++;
      if (outs !== 4'b0001) $display("FAIL lu_rs_stall got=%b exp=0001", outs);
      else passes++;
      tick();
      idex_mem_read = 1'b0;
      #2;
      checks++;
      if (outs !== 4'b1100) $display("FAIL lu_released got=%b exp=1100", outs);
      else passes++;
      tick();
      idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      #2;
      checks++;
      if (outs !== 4'b1100) $display("FAIL lu_r0_nostall got=%b exp=1100", outs);
      else passes++;
      tick();
      idex_rt = 5'd3; ifid_rs = 5'd9; ifid_rt = 5'd3;
      #2;
      checks++;
      if (outs !== 4'b0001) $display("FAIL lu_rt_stall got=%b exp=0001", outs);
      else passes++;
      tick();
      idex_mem_read = 1'b0;
      #2;
      checks++;
      if (stall_cycles !== exp_stall(2)) $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cycles, exp_stall(2));
      else passes++;
      $display("test_load_use done");
   endtask

   task automatic test_branch();
      apply_reset();
      branch_taken = 1'b1;
      #2;
      checks++;
      if (outs !== 4'b1010) $display("FAIL br_cycle0 got=%b exp=1010", outs);
      else passes++;
      tick();
      branch_taken = 1'b0;
      #2;
      checks++;
      if (outs !== 4'b1010) $display("FAIL br_cycle1 got=%b exp=1010", outs);
      else passes++;
      tick();
      checks++;
      if (outs !== 4'b1100 || dut.state_q !== ST_RUN)
         $display("FAIL br_after got=%b state=%0d exp=1100 state=0", outs, dut.state_q);
      else passes++;
      branch_taken = 1'b1; hit = 1'b0;
      #2;
      checks++;
      if (outs !== 4'b1010) $display("FAIL br_vs_miss got=%b exp=1010", outs);
      else passes++;
      tick();
      branch_taken = 1'b0; hit = 1'b1;
      #2;
      checks++;
      if (dut.state_q !== ST_FLUSH || outs !== 4'b1010)
         $display("FAIL br_no_miss got state=%0d outs=%b exp state=2 outs=1010", dut.state_q, outs);
      else passes++;
      tick();
      hit = 1'b0;
      tick();
      branch_taken = 1'b1;
      #2;
      checks++;
      if (outs !== 4'b1010) $display("FAIL br_in_miss got=%b exp=1010", outs);
      else passes++;
      tick();
      branch_taken = 1'b0; hit = 1'b1;
      #2;
      checks++;
      if (dut.state_q !== ST_FLUSH || dut.miss_cnt_q !== 7'd0)
         $display("FAIL br_in_miss_state got state=%0d cnt=%0d exp state=2 cnt=0", dut.state_q, dut.miss_cnt_q);
      else passes++;
      tick();
      $display("test_branch done");
   endtask

   task automatic test_timeout();
      apply_reset();
      hit = 1'b0;
      for (int i = 0; i < 63; i++) tick();
      checks++;
      if (miss_err !== 1'b0) $display("FAIL to_before got=%b exp=0", miss_err);
      else passes++;
      tick();
      checks++;
      if (miss_err !== 1'b1) $display("FAIL to_at64 got=%b exp=1", miss_err);
      else passes++;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (dut.miss_cnt_q !== 7'd64) $display("FAIL to_saturate got=%0d exp=64", dut.miss_cnt_q);
      else passes++;
      hit = 1'b1;
      tick();
      checks++;
      if (miss_err !== 1'b1 || outs !== 4'b1100)
         $display("FAIL to_sticky got err=%b outs=%b exp err=1 outs=1100", miss_err, outs);
      else passes++;
      $display("test_timeout done");
   endtask

   task automatic test_reset_mid_miss();
      hit = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== 4'b0011 || miss_err !== 1'b0)
         $display("FAIL rmm_async got outs=%b err=%b exp outs=0011 err=0", outs, miss_err);
      else passes++;
      hit = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (dut.state_q !== ST_RUN || dut.miss_cnt_q !== 7'd0 || miss_err !== 1'b0 || outs !== 4'b1100)
         $display("FAIL rmm_release got state=%0d cnt=%0d err=%b outs=%b exp 0/0/0/1100",
                  dut.state_q, dut.miss_cnt_q, miss_err, outs);
      else passes++;
      $display("test_reset_mid_miss done");
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_run();
      test_miss();
      test_load_use();
      test_branch();
      test_timeout();
      test_reset_mid_miss();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
